// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel, W-bit valid/ready stream multiplexer.
// A round-robin arbiter picks one channel per cycle into a single-entry
// registered output stage.
// Optional packet lock: define STREAM_MUX_RR_LOCK_EN. This adds in_last/out_last
// and holds the grant on one channel until it sends the end of its packet.
module stream_mux_rr #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         in_valid,
  input  logic [N*W-1:0]       in_data,
  output logic [N-1:0]         in_ready,
`ifdef STREAM_MUX_RR_LOCK_EN
  input  logic [N-1:0]         in_last,
  output logic                 out_last,
`endif
  output logic                 out_valid,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_sel,
  input  logic                 out_ready
);

  localparam int unsigned SELW = $clog2(N);

  logic [SELW-1:0] ptr_q, ptr_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [SELW-1:0] out_sel_q, out_sel_d;

  logic            can_accept_c;
  logic            grant_vld_c;
  logic [SELW-1:0] grant_c;
  logic [SELW-1:0] cand_c;
  logic            xfer_c;

`ifdef STREAM_MUX_RR_LOCK_EN
  logic            lock_q, lock_d;
  logic [SELW-1:0] lock_sel_q, lock_sel_d;
  logic            out_last_q, out_last_d;
  logic            xfer_last_c;
`endif

  assign can_accept_c = !out_valid_q || out_ready;

  // Round-robin search starting one past the last-served channel.
  always_comb begin
    grant_vld_c = 1'b0;
    grant_c     = '0;
    cand_c      = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand_c = SELW'((32'(ptr_q) + k) % N);
      if (!grant_vld_c && in_valid[cand_c]) begin
        grant_vld_c = 1'b1;
        grant_c     = cand_c;
      end
    end
`ifdef STREAM_MUX_RR_LOCK_EN
    // An open packet keeps the grant even while its producer idles.
    if (lock_q) begin
      grant_vld_c = 1'b1;
      grant_c     = lock_sel_q;
    end
`endif
  end

  assign xfer_c = can_accept_c && grant_vld_c && in_valid[grant_c];

`ifdef STREAM_MUX_RR_LOCK_EN
  assign xfer_last_c = in_last[grant_c];
`endif

  // One-hot ready to the granted channel; this stays silent during reset.
  always_comb begin
    in_ready = '0;
    if (rst_n && can_accept_c && grant_vld_c) begin
      in_ready[grant_c] = 1'b1;
    end
  end

  // Next-state for the output register, pointer and lock.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
`ifdef STREAM_MUX_RR_LOCK_EN
    lock_d      = lock_q;
    lock_sel_d  = lock_sel_q;
    out_last_d  = out_last_q;
`endif
    if (xfer_c) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[32'(grant_c)*W +: W];
      out_sel_d   = grant_c;
`ifdef STREAM_MUX_RR_LOCK_EN
      out_last_d  = xfer_last_c;
      lock_d      = !xfer_last_c;
      lock_sel_d  = grant_c;
      if (xfer_last_c) begin
        ptr_d = grant_c;
      end
`else
      ptr_d       = grant_c;
`endif
    end else if (can_accept_c) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers; the pointer resets to N-1 so channel 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= SELW'(N - 1);
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
`ifdef STREAM_MUX_RR_LOCK_EN
      lock_q      <= 1'b0;
      lock_sel_q  <= '0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
`ifdef STREAM_MUX_RR_LOCK_EN
      lock_q      <= lock_d;
      lock_sel_q  <= lock_sel_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
`ifdef STREAM_MUX_RR_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed table-driven bench for stream_mux_rr with N=4 and W=8.
// It also checks a hand-written asynchronous reset sequence.
// It checks the packet lock sequence when STREAM_MUX_RR_LOCK_EN is defined.
module tb_stream_mux_rr;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   out_sel;
  logic         out_ready;
`ifdef STREAM_MUX_RR_LOCK_EN
  logic [N-1:0] in_last;
  logic         out_last;
`endif

  int checks   = 0;
  int failures = 0;

  stream_mux_rr #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef STREAM_MUX_RR_LOCK_EN
    .in_last   (in_last),
    .out_last  (out_last),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    logic [3:0]  v;
    logic [31:0] d;
    logic        r;
    logic [3:0]  erdy;
    logic        eov;
    logic [7:0]  eod;
    logic [1:0]  eos;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit rst, logic [3:0] v, logic [31:0] d, logic r,
                              logic [3:0] erdy, logic eov, logic [7:0] eod, logic [1:0] eos);
    vec_t e;
    e.rst = rst; e.v = v; e.d = d; e.r = r;
    e.erdy = erdy; e.eov = eov; e.eod = eod; e.eos = eos;
    tbl.push_back(e);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = '1;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    @(negedge clk);
    in_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Producer protocol monitor: a pending valid must hold with stable data.
  logic [N-1:0]   pv;
  logic [N-1:0]   pr;
  logic [N*W-1:0] pd;
  logic           prst = 1'b0;
  always begin
    @(negedge clk);
    #4;
    if (rst_n && prst) begin
      for (int i = 0; i < int'(N); i++) begin
        if (pv[i] && !pr[i] && (!in_valid[i] || in_data[i*8 +: 8] !== pd[i*8 +: 8])) begin
          failures++;
          $display("FAIL proto_ch%0d valid=%0b data=%0h held_data=%0h", i, in_valid[i],
                   in_data[i*8 +: 8], pd[i*8 +: 8]);
        end
      end
    end
    pv   = in_valid;
    pr   = in_ready;
    pd   = in_data;
    prst = rst_n;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef STREAM_MUX_RR_LOCK_EN
    in_last   = '1;
`endif

    // Idle after reset.
    add(1, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
    for (int i = 0; i < 4; i++) add(0, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0);
    // All four channels valid: fair rotation 0,1,2,3,0,1,2,3.
    add(1, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0);
    add(0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA0, 2'd0);
    add(0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA1, 2'd1);
    add(0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA2, 2'd2);
    add(0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA3, 2'd3);
    add(0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0010, 1'b1, 8'hA0, 2'd0);
    add(0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0100, 1'b1, 8'hA1, 2'd1);
    add(0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b1000, 1'b1, 8'hA2, 2'd2);
    add(0, 4'b1111, 32'hA3A2A1A0, 1'b1, 4'b0001, 1'b1, 8'hA3, 2'd3);
    // Single channel 2: back-to-back beats 10..15, then the register drains.
    add(1, 4'b0100, 32'h00100000, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0);
    add(0, 4'b0100, 32'h00110000, 1'b1, 4'b0100, 1'b1, 8'h10, 2'd2);
    add(0, 4'b0100, 32'h00120000, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd2);
    add(0, 4'b0100, 32'h00130000, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2);
    add(0, 4'b0100, 32'h00140000, 1'b1, 4'b0100, 1'b1, 8'h13, 2'd2);
    add(0, 4'b0100, 32'h00150000, 1'b1, 4'b0100, 1'b1, 8'h14, 2'd2);
    add(0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b1, 8'h15, 2'd2);
    add(0, 4'b0000, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h15, 2'd2);
    // Channels 1 and 3 under a 4-cycle stall, then alternating beats.
    add(1, 4'b1010, 32'h31001100, 1'b0, 4'b0010, 1'b0, 8'h00, 2'd0);
    add(0, 4'b1010, 32'h31001200, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1);
    add(0, 4'b1010, 32'h31001200, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1);
    add(0, 4'b1010, 32'h31001200, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd1);
    add(0, 4'b1010, 32'h31001200, 1'b1, 4'b1000, 1'b1, 8'h11, 2'd1);
    add(0, 4'b1010, 32'h32001200, 1'b1, 4'b0010, 1'b1, 8'h31, 2'd3);
    add(0, 4'b1010, 32'h32001300, 1'b1, 4'b1000, 1'b1, 8'h12, 2'd1);
    add(0, 4'b1010, 32'h33001300, 1'b1, 4'b0010, 1'b1, 8'h32, 2'd3);
    add(0, 4'b1010, 32'h33001300, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd1);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      @(negedge clk);
      in_valid  = tbl[i].v;
      in_data   = tbl[i].d;
      out_ready = tbl[i].r;
      #1;
      chk($sformatf("row%0d_in_ready", i),  32'(in_ready),  32'(tbl[i].erdy));
      chk($sformatf("row%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
      chk($sformatf("row%0d_out_data", i),  32'(out_data),  32'(tbl[i].eod));
      chk($sformatf("row%0d_out_sel", i),   32'(out_sel),   32'(tbl[i].eos));
    end

    // Asynchronous reset while the output register holds 8'h5C.
    do_reset();
    @(negedge clk);
    in_valid  = 4'b0001;
    in_data   = 32'h0000005C;
    out_ready = 1'b0;
    #1;
    chk("arst_accept_rdy", 32'(in_ready), 32'h1);
    @(negedge clk);
    #1;
    chk("arst_hold_valid", 32'(out_valid), 32'h1);
    chk("arst_hold_data",  32'(out_data),  32'h5C);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid_drop", 32'(out_valid), 32'h0);
    chk("arst_data_clear", 32'(out_data),  32'h0);
    chk("arst_ready_low",  32'(in_ready),  32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 4'b1111;
    in_data   = 32'hA3A2A1A0;
    out_ready = 1'b1;
    #1;
    chk("arst_prio_rdy", 32'(in_ready), 32'h1);
    @(negedge clk);
    #1;
    chk("arst_prio_sel",  32'(out_sel),  32'h0);
    chk("arst_prio_data", 32'(out_data), 32'hA0);

`ifdef STREAM_MUX_RR_LOCK_EN
    // Channel 0 sends a 3-beat packet while channel 1 stays valid.
    do_reset();
    @(negedge clk);
    in_valid = 4'b0011; in_data = 32'h00007701; in_last = 4'b0010; out_ready = 1'b1;
    #1;
    chk("lock0_rdy", 32'(in_ready), 32'h1);
    chk("lock0_ov",  32'(out_valid), 32'h0);
    @(negedge clk);
    in_data = 32'h00007702;
    #1;
    chk("lock1_rdy",  32'(in_ready), 32'h1);
    chk("lock1_data", 32'(out_data), 32'h01);
    chk("lock1_last", 32'(out_last), 32'h0);
    @(negedge clk);
    in_data = 32'h00007703; in_last = 4'b0011;
    #1;
    chk("lock2_rdy",  32'(in_ready), 32'h1);
    chk("lock2_data", 32'(out_data), 32'h02);
    chk("lock2_last", 32'(out_last), 32'h0);
    @(negedge clk);
    in_valid = 4'b0010; in_last = 4'b0010;
    #1;
    chk("lock3_rdy",  32'(in_ready), 32'h2);
    chk("lock3_data", 32'(out_data), 32'h03);
    chk("lock3_last", 32'(out_last), 32'h1);
    @(negedge clk);
    in_valid = 4'b0000;
    #1;
    chk("lock4_sel",  32'(out_sel),  32'h1);
    chk("lock4_data", 32'(out_data), 32'h77);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
